// File: rtl/adc_scan_pkg.sv
// Shared types, constants and parameter checks for the ADC scan sequencer.
package adc_scan_pkg;

  localparam int ADC_CH_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACC,
    NEXT
  } scan_state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic bit params_legal(input int num_ch, input int ch_base,
                                      input int data_w, input int out_w,
                                      input int avg_log2, input int timeout);
    return (num_ch >= 1) && (num_ch <= 16) && (ch_base >= 0) &&
           (ch_base + num_ch - 1 <= 31) && (data_w >= 1) && (out_w >= data_w) &&
           (avg_log2 >= 0) && (avg_log2 <= 6) && (timeout >= 4);
  endfunction

endpackage

// File: rtl/adc_avg_accum.sv
// Sample accumulator and counter; reports the average on the last sample of a block.
module adc_avg_accum
  import adc_scan_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 2,
  parameter int OUT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              add,
  input  logic              clear,
  input  logic [DATA_W-1:0] data,
  output logic [OUT_W-1:0]  avg_value,
  output logic              avg_done
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] sum;

  // The average is formed from the sum including the incoming sample, so the
  // result can be written in the same cycle the last sample is added.
  assign sum       = acc + ACC_W'(data);
  assign avg_done  = add && (cnt == CNT_LAST);
  assign avg_value = OUT_W'(sum >> AVG_LOG2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear || avg_done) begin
      acc <= '0;
      cnt <= '0;
    end else if (add) begin
      acc <= sum;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Round-robin ADC channel scanner with per-channel averaging and response timeout.
//   state | meaning
//   IDLE  | parked, waiting for enable
//   ISSUE | command presented, waiting for cmd_ready
//   WAIT  | command accepted, waiting for matching response or timeout
//   ACC   | sample absorbed; decide whether the channel's average is complete
//   NEXT  | advance to the next channel, pulse scan_done on wrap
module adc_scan_sequencer
  import adc_scan_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int CH_BASE  = 1,
  parameter int DATA_W   = 12,
  parameter int OUT_W    = 16,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  output logic                    cmd_valid,
  output logic [ADC_CH_W-1:0]     cmd_channel,
  input  logic                    cmd_ready,
  input  logic                    rsp_valid,
  input  logic [ADC_CH_W-1:0]     rsp_channel,
  input  logic [DATA_W-1:0]       rsp_data,
  output logic [NUM_CH*OUT_W-1:0] adc_data,
  output logic [NUM_CH-1:0]       ch_valid,
  output logic [NUM_CH-1:0]       ch_error,
  output logic                    scan_done,
  output logic [15:0]             timeout_cnt
);

  localparam int IDX_W = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
  localparam int TMR_W = clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  if (!params_legal(NUM_CH, CH_BASE, DATA_W, OUT_W, AVG_LOG2, TIMEOUT)) begin : g_bad_params
    $error("adc_scan_sequencer: illegal parameter combination");
  end

  scan_state_t state, state_nxt;

  logic [IDX_W-1:0]              idx;
  logic [TMR_W-1:0]              timer;
  logic                          done_q;
  logic [ADC_CH_W-1:0]           cur_ch;
  logic                          match;
  logic                          acc_add;
  logic                          acc_clear;
  logic                          timer_clr;
  logic                          timer_inc;
  logic                          timed_out;
  logic                          idx_adv;
  logic [OUT_W-1:0]              avg_value;
  logic                          avg_done;
  logic [NUM_CH-1:0][OUT_W-1:0]  data_bank;

  assign cur_ch      = ADC_CH_W'(CH_BASE) + ADC_CH_W'(idx);
  // Channel reads as 0 while parked so the port is quiet after reset.
  assign cmd_channel = (state == IDLE) ? '0 : cur_ch;
  assign match       = rsp_valid && (rsp_channel == cur_ch);
  assign adc_data    = data_bank;

  adc_avg_accum #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2),
    .OUT_W    (OUT_W)
  ) u_accum (
    .clk       (clk),
    .rst       (rst),
    .add       (acc_add),
    .clear     (acc_clear),
    .data      (rsp_data),
    .avg_value (avg_value),
    .avg_done  (avg_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_valid = 1'b0;
    acc_add   = 1'b0;
    acc_clear = 1'b0;
    timer_clr = 1'b0;
    timer_inc = 1'b0;
    timed_out = 1'b0;
    idx_adv   = 1'b0;
    scan_done = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = ISSUE;
      end
      ISSUE: begin
        cmd_valid = 1'b1;
        if (cmd_ready) begin
          timer_clr = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // A matching response beats a timeout landing in the same cycle.
        if (match) begin
          acc_add   = 1'b1;
          state_nxt = ACC;
        end else if (timer == TMR_LAST) begin
          timed_out = 1'b1;
          acc_clear = 1'b1;
          state_nxt = NEXT;
        end else begin
          timer_inc = 1'b1;
        end
      end
      ACC: begin
        if (done_q)      state_nxt = NEXT;
        else if (enable) state_nxt = ISSUE;
        else             state_nxt = IDLE;
      end
      NEXT: begin
        idx_adv   = 1'b1;
        scan_done = (idx == IDX_LAST);
        state_nxt = enable ? ISSUE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      timer  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= avg_done;
      if (timer_clr)      timer <= '0;
      else if (timer_inc) timer <= timer + 1'b1;
      if (idx_adv) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_bank   <= '0;
      ch_valid    <= '0;
      ch_error    <= '0;
      timeout_cnt <= '0;
    end else begin
      if (avg_done) begin
        data_bank[idx] <= avg_value;
        ch_valid[idx]  <= 1'b1;
        ch_error[idx]  <= 1'b0;
      end
      if (timed_out) begin
        ch_error[idx] <= 1'b1;
        if (timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
      end
    end
  end

endmodule
